// File: rtl/hps_csr_pkg.sv
// Register map, ID constant and error-bit layout for the HPS CSR bridge.
// Shared by the bridge top level and the interrupt controller.
package hps_csr_pkg;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_CTRL     = 8'h04;
  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_RX_DATA  = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_IRQ_PEND = 8'h14;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h18;
  localparam logic [7:0] OFF_RX_THR   = 8'h1C;
  localparam logic [7:0] OFF_COMP_THR = 8'h20;
  localparam logic [7:0] OFF_GUARD    = 8'h24;
  localparam logic [7:0] OFF_MEM_ADDR = 8'h28;
  localparam logic [7:0] OFF_END_ADDR = 8'h2C;
  localparam logic [7:0] OFF_LED      = 8'h30;
  localparam logic [7:0] OFF_ERR      = 8'h34;

  localparam logic [31:0] CSR_ID = 32'h4850_0002;

  localparam int CTRL_TX_START    = 0;
  localparam int CTRL_NAVIG_START = 1;

  localparam int ERR_RX_UNF = 0;
  localparam int ERR_TX_OVF = 1;

  // Sticky error flags, packed so the register reads back as {tx_ovf, rx_unf}.
  typedef struct packed {
    logic tx_ovf;
    logic rx_unf;
  } err_t;

endpackage

// File: rtl/hps_irq_ctrl.sv
// Edge-triggered interrupt aggregator: sticky pending bits, mask, W1C clear, one level irq.
// Latency: pend 2 cycles after a source rises, irq 1 cycle after pend/mask; no backpressure.
module hps_irq_ctrl
  import hps_csr_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_src,
  input  logic               i_mask_we,
  input  logic [NUM_IRQ-1:0] i_mask_wd,
  input  logic               i_w1c_we,
  input  logic [NUM_IRQ-1:0] i_w1c_wd,
  output logic [NUM_IRQ-1:0] o_pend,
  output logic [NUM_IRQ-1:0] o_mask,
  output logic               o_irq
);

  logic [NUM_IRQ-1:0] r_src;
  logic [NUM_IRQ-1:0] r_src_d;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_irq;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_edge = r_src & ~r_src_d;
  assign w_clr  = i_w1c_we ? i_w1c_wd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src   <= '0;
      r_src_d <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_src   <= i_src;
      r_src_d <= r_src;
      // A fresh edge overrides a clear landing in the same cycle.
      r_pend  <= (r_pend & ~w_clr) | w_edge;
      if (i_mask_we) begin
        r_mask <= i_mask_wd;
      end
      r_irq   <= |(r_pend & r_mask);
    end
  end

  assign o_pend = r_pend;
  assign o_mask = r_mask;
  assign o_irq  = r_irq;

endmodule

// File: rtl/hps_csr_bridge.sv
// Avalon-MM CSR bank bridging the HPS to the modem fabric: FIFO push/pop, start pulses, config, irq.
// Latency: readdata and all strobes registered, 1 cycle after the access; slave never stalls.
module hps_csr_bridge
  import hps_csr_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_IRQ      = 4,
  parameter int ADDR_W       = 8,
  parameter int RX_THR_RST   = 600,
  parameter int COMP_THR_RST = 6,
  parameter int GUARD_RST    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wren,
  input  logic              tx_full,
  input  logic              tx_ready,
  output logic              tx_start,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_rden,
  input  logic              rx_empty,
  input  logic [7:0]        rx_level,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic              irq,
  output logic              navig_start,
  output logic [7:0]        led,
  output logic [31:0]       rx_threshold,
  output logic [31:0]       comp_threshold,
  output logic [31:0]       guard_interval,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       end_address
);

  logic [31:0]       r_readdata;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_wren;
  logic              r_rx_rden;
  logic              r_tx_start;
  logic              r_navig_start;
  logic [7:0]        r_led;
  logic [31:0]       r_rx_thr;
  logic [31:0]       r_comp_thr;
  logic [31:0]       r_guard;
  logic [31:0]       r_mem_addr;
  err_t              r_err;

  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_rdata;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_mask;
  logic               w_irq;

  // A simultaneous read and write strobe is treated as a write only.
  assign w_wr = chipselect & write_en;
  assign w_rd = chipselect & read_en & ~write_en;

  function automatic logic at(input logic [ADDR_W-1:0] a, input logic [7:0] off);
    return a == ADDR_W'(off);
  endfunction

  always_comb begin
    w_rdata = '0;
    case (1'b1)
      at(address, OFF_ID):       w_rdata = CSR_ID;
      at(address, OFF_RX_DATA):  w_rdata = rx_empty ? '0 : 32'(rx_data);
      at(address, OFF_STATUS):   w_rdata = {21'b0, tx_ready, tx_full, rx_empty, rx_level};
      at(address, OFF_IRQ_PEND): w_rdata = 32'(w_pend);
      at(address, OFF_IRQ_MASK): w_rdata = 32'(w_mask);
      at(address, OFF_RX_THR):   w_rdata = r_rx_thr;
      at(address, OFF_COMP_THR): w_rdata = r_comp_thr;
      at(address, OFF_GUARD):    w_rdata = r_guard;
      at(address, OFF_MEM_ADDR): w_rdata = r_mem_addr;
      at(address, OFF_END_ADDR): w_rdata = end_address;
      at(address, OFF_LED):      w_rdata = {24'b0, r_led};
      at(address, OFF_ERR):      w_rdata = {30'b0, r_err};
      default:                   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata    <= '0;
      r_tx_data     <= '0;
      r_tx_wren     <= 1'b0;
      r_rx_rden     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_navig_start <= 1'b0;
      r_led         <= '0;
      r_rx_thr      <= 32'(RX_THR_RST);
      r_comp_thr    <= 32'(COMP_THR_RST);
      r_guard       <= 32'(GUARD_RST);
      r_mem_addr    <= '0;
      r_err         <= '0;
    end else begin
      r_tx_wren     <= 1'b0;
      r_rx_rden     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_navig_start <= 1'b0;

      if (w_wr) begin
        if (at(address, OFF_CTRL)) begin
          r_tx_start    <= writedata[CTRL_TX_START];
          r_navig_start <= writedata[CTRL_NAVIG_START];
        end
        if (at(address, OFF_RX_THR))   r_rx_thr   <= writedata;
        if (at(address, OFF_COMP_THR)) r_comp_thr <= writedata;
        if (at(address, OFF_GUARD))    r_guard    <= writedata;
        if (at(address, OFF_MEM_ADDR)) r_mem_addr <= writedata;
        if (at(address, OFF_LED))      r_led      <= writedata[7:0];
        if (at(address, OFF_ERR))      r_err      <= r_err & ~err_t'(writedata[1:0]);
        if (at(address, OFF_TX_DATA)) begin
          if (tx_full) begin
            r_err.tx_ovf <= 1'b1;
          end else begin
            r_tx_data <= writedata[DATA_W-1:0];
            r_tx_wren <= 1'b1;
          end
        end
      end

      if (w_rd) begin
        r_readdata <= w_rdata;
        // Popping an empty FIFO is refused and flagged; the mux already returns 0.
        if (at(address, OFF_RX_DATA)) begin
          if (rx_empty) r_err.rx_unf <= 1'b1;
          else          r_rx_rden    <= 1'b1;
        end
      end
    end
  end

  hps_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk       (clk),
    .reset     (reset),
    .i_src     (irq_src),
    .i_mask_we (w_wr & at(address, OFF_IRQ_MASK)),
    .i_mask_wd (writedata[NUM_IRQ-1:0]),
    .i_w1c_we  (w_wr & at(address, OFF_IRQ_PEND)),
    .i_w1c_wd  (writedata[NUM_IRQ-1:0]),
    .o_pend    (w_pend),
    .o_mask    (w_mask),
    .o_irq     (w_irq)
  );

  assign readdata       = r_readdata;
  assign tx_data        = r_tx_data;
  assign tx_wren        = r_tx_wren;
  assign rx_rden        = r_rx_rden;
  assign tx_start       = r_tx_start;
  assign navig_start    = r_navig_start;
  assign led            = r_led;
  assign rx_threshold   = r_rx_thr;
  assign comp_threshold = r_comp_thr;
  assign guard_interval = r_guard;
  assign mem_addr       = r_mem_addr;
  assign irq            = w_irq;

endmodule
